// File: rtl/ppe_request_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ppe_request_buffer
// Purpose  : Requester side of a round-robin PPE arbiter. Keeps one small FIFO
//            per source, raises a request for each non-empty FIFO, pops the
//            FIFO named by a legal one-hot grant and presents the popped word
//            on a registered output.
// Ports    : clk, reset_n (sync, active low), ce (clock enable)
//            i_data_val/i_data    per-source write strobe and write data
//            o_full               per-source FIFO full (writes dropped)
//            o_request            to arbiter; bit i = FIFO i non-empty
//            i_grant              from arbiter; one-hot or zero
//            o_data_val/o_data/o_src  registered popped word and its source
//            o_error              sticky illegal-grant flag
// Revision : 1.0 - initial release
// ============================================================================
module ppe_request_buffer #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [0:N-1]          i_data_val,
  input  logic [0:N-1][W-1:0]   i_data,
  output logic [0:N-1]          o_full,
  output logic [0:N-1]          o_request,
  input  logic [0:N-1]          i_grant,
  output logic                  o_data_val,
  output logic [W-1:0]          o_data,
  output logic [$clog2(N)-1:0]  o_src,
  output logic                  o_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(N);
  localparam int GW = $clog2(N + 1);

  // Per-source FIFO state
  logic [W-1:0]  mem_q    [N][DEPTH];
  logic [AW-1:0] wr_ptr_q [N];
  logic [AW-1:0] wr_ptr_d [N];
  logic [AW-1:0] rd_ptr_q [N];
  logic [AW-1:0] rd_ptr_d [N];
  logic [CW-1:0] count_q  [N];
  logic [CW-1:0] count_d  [N];

  // Output registers
  logic          data_val_q, data_val_d;
  logic [W-1:0]  data_q,     data_d;
  logic [SW-1:0] src_q,      src_d;
  logic          error_q,    error_d;

  // Grant decode
  logic [GW-1:0] grant_ones;
  logic [SW-1:0] grant_idx;
  logic          grant_hits_req;
  logic          grant_legal;
  logic [0:N-1]  wr_en;
  logic [0:N-1]  pop_en;

  // Request/full come from registered counts only, so there is no
  // combinational path from i_grant back to o_request through the arbiter.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      o_request[i] = (count_q[i] != '0);
      o_full[i]    = (count_q[i] == CW'(DEPTH));
    end
  end

  // A grant is legal only if exactly one bit is set and that source requests.
  always_comb begin
    grant_ones     = '0;
    grant_idx      = '0;
    grant_hits_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_grant[i]) begin
        grant_ones = grant_ones + GW'(1);
        grant_idx  = SW'(i);
        if (count_q[i] != '0) begin
          grant_hits_req = 1'b1;
        end
      end
    end
    grant_legal = (grant_ones == GW'(1)) && grant_hits_req;
  end

  // Next-state for FIFO pointers and counts. Full is judged on the
  // pre-pop count, so a full FIFO refuses a write even while being popped.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wr_en[i]    = ce & i_data_val[i] & ~o_full[i];
      pop_en[i]   = ce & grant_legal & i_grant[i];
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(wr_en[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop_en[i]);
      count_d[i]  = count_q[i] + CW'(wr_en[i]) - CW'(pop_en[i]);
    end
  end

  // Output register next-state; everything holds while ce is low.
  always_comb begin
    data_val_d = data_val_q;
    data_d     = data_q;
    src_d      = src_q;
    error_d    = error_q;
    if (ce) begin
      data_val_d = grant_legal;
      if (grant_legal) begin
        data_d = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        src_d  = grant_idx;
      end
      if ((|i_grant) && !grant_legal) begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      data_val_q <= 1'b0;
      data_q     <= '0;
      src_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      data_val_q <= data_val_d;
      data_q     <= data_d;
      src_q      <= src_d;
      error_q    <= error_d;
    end
  end

  // Storage has no reset; stale contents are never read because counts
  // are cleared. A write is blocked during reset so nothing leaks through.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset_n && wr_en[i]) begin
        mem_q[i][wr_ptr_q[i]] <= i_data[i];
      end
    end
  end

  assign o_data_val = data_val_q;
  assign o_data     = data_q;
  assign o_src      = src_q;
  assign o_error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ppe_request_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppe_request_buffer
// Purpose  : Self-checking bench for ppe_request_buffer. A queue-based model
//            of the per-source FIFOs produces expected pops into a
//            scoreboard; a monitor on the falling edge checks outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppe_request_buffer;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(N);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 ce;
  logic [0:N-1]         i_data_val;
  logic [0:N-1][W-1:0]  i_data;
  logic [0:N-1]         o_full;
  logic [0:N-1]         o_request;
  logic [0:N-1]         i_grant;
  logic                 o_data_val;
  logic [W-1:0]         o_data;
  logic [SW-1:0]        o_src;
  logic                 o_error;

  ppe_request_buffer #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .i_data_val (i_data_val),
    .i_data     (i_data),
    .o_full     (o_full),
    .o_request  (o_request),
    .i_grant    (i_grant),
    .o_data_val (o_data_val),
    .o_data     (o_data),
    .o_src      (o_src),
    .o_error    (o_error)
  );

  always #5 clk = ~clk;

  // Reference model: one queue of words per source
  logic [W-1:0]    mq [N][$];
  logic [SW+W-1:0] sb [$];
  int              rr_last = N - 1;

  // Expected observable state after the most recent edge
  logic [0:N-1]  exp_req  = '0;
  logic [0:N-1]  exp_full = '0;
  logic          exp_err  = 1'b0;
  logic          exp_val  = 1'b0;
  logic [W-1:0]  exp_data = '0;
  logic [SW-1:0] exp_src  = '0;
  logic          act      = 1'b0;
  logic          started  = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  // Monitor: compare outputs and pop the scoreboard on each fresh word.
  always @(negedge clk) begin
    if (started) begin
      chk("request",  64'(o_request),  64'(exp_req));
      chk("full",     64'(o_full),     64'(exp_full));
      chk("error",    64'(o_error),    64'(exp_err));
      chk("data_val", 64'(o_data_val), 64'(exp_val));
      chk("data_hold", 64'(o_data),    64'(exp_data));
      chk("src_hold",  64'(o_src),     64'(exp_src));
      if (act && o_data_val) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 64'(1), 64'(0));
        end else begin
          logic [SW+W-1:0] e;
          e = sb.pop_front();
          chk("sb_pop", 64'({o_src, o_data}), 64'(e));
        end
      end
    end
  end

  function automatic logic [0:N-1] rr_grant();
    logic [0:N-1] g;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (rr_last + k) % N;
      if (mq[idx].size() > 0) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Drive one cycle, advance the model across the edge, publish expectations.
  task automatic step(input logic c, input logic r, input logic [0:N-1] dv,
                      input logic [0:N-1][W-1:0] d, input logic [0:N-1] g);
    logic          nv;
    logic [W-1:0]  nd;
    logic [SW-1:0] ns;
    logic          ne;
    nv = exp_val; nd = exp_data; ns = exp_src; ne = exp_err;
    reset_n = r; ce = c; i_data_val = dv; i_data = d; i_grant = g;
    if (!r) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      nv = 1'b0; nd = '0; ns = '0; ne = 1'b0;
      rr_last = N - 1;
    end else if (c) begin
      logic [0:N-1] acc;
      int gi;
      bit legal;
      gi = 0;
      for (int i = 0; i < N; i++) begin
        acc[i] = dv[i] && (mq[i].size() < DEPTH);
        if (g[i]) gi = i;
      end
      legal = ($countones(g) == 1) && (mq[gi].size() > 0);
      nv = legal;
      if (legal) begin
        nd = mq[gi].pop_front();
        ns = SW'(gi);
        sb.push_back({ns, nd});
        rr_last = gi;
      end else if (g != '0) begin
        ne = 1'b1;
      end
      for (int i = 0; i < N; i++) if (acc[i]) mq[i].push_back(d[i]);
    end
    @(posedge clk);
    #2;
    exp_val = nv; exp_data = nd; exp_src = ns; exp_err = ne;
    act = c && r;
    for (int i = 0; i < N; i++) begin
      exp_req[i]  = mq[i].size() != 0;
      exp_full[i] = mq[i].size() == DEPTH;
    end
    started = 1'b1;
  endtask

  logic [0:N-1][W-1:0] d;
  logic [0:N-1][W-1:0] z = '0;

  initial begin
    reset_n = 1'b0; ce = 1'b0; i_data_val = '0; i_data = '0; i_grant = '0;

    // Reset, including while ce is low
    step(1'b0, 1'b0, '0, z, '0);
    step(1'b1, 1'b0, '0, z, '0);

    // Fill src 2, overflow write dropped, then drain with grants to src 2
    for (int k = 0; k < 5; k++) begin
      d = '0; d[2] = 32'hA0 + k;
      step(1'b1, 1'b1, 4'b0010, d, '0);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, '0, z, 4'b0010);
    step(1'b1, 1'b1, '0, z, '0);

    // One word per source, round-robin grants from reset order
    step(1'b1, 1'b0, '0, z, '0);
    d = {32'hB0, 32'hB1, 32'hB2, 32'hB3};
    step(1'b1, 1'b1, 4'b1111, d, '0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, '0, z, rr_grant());
    step(1'b1, 1'b1, '0, z, '0);

    // Src 1 full: write+grant drops the write; next write+grant does both
    for (int k = 0; k < 4; k++) begin
      d = '0; d[1] = 32'hC0 + k;
      step(1'b1, 1'b1, 4'b0100, d, '0);
    end
    d = '0; d[1] = 32'hC4;
    step(1'b1, 1'b1, 4'b0100, d, 4'b0100);
    d = '0; d[1] = 32'hC5;
    step(1'b1, 1'b1, 4'b0100, d, 4'b0100);

    // Multi-hot grant with both requesting: error, no pop; error stays
    d = '0; d[0] = 32'hD0;
    step(1'b1, 1'b1, 4'b1000, d, '0);
    step(1'b1, 1'b1, '0, z, 4'b1100);
    step(1'b1, 1'b1, '0, z, rr_grant());
    step(1'b1, 1'b1, '0, z, rr_grant());

    // ce low: everything holds
    d = {32'hE0, 32'hE1, 32'hE2, 32'hE3};
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'b1111, d, 4'b1000);

    // Reset with words queued
    step(1'b1, 1'b0, 4'b1111, d, 4'b0100);
    step(1'b1, 1'b1, '0, z, '0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [0:N-1] g;
      logic [0:N-1] dv;
      int sel;
      for (int i = 0; i < N; i++) d[i] = $urandom;
      dv  = 4'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 3)       g = '0;
      else if (sel < 16) g = rr_grant();
      else if (sel < 18) begin g = '0; g[$urandom_range(0, N-1)] = 1'b1; end
      else               g = 4'($urandom);
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 199) != 0), dv, d, g);
    end
    step(1'b1, 1'b1, '0, z, '0);

    @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
